// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared width default, opcode constants and flag record for the alu slice
package alu_pkg;

  localparam int WIDTH_DEFAULT = 16;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
  } alu_flags_t;

  localparam alu_flags_t FLAGS_CLEAR = '{zero: 1'b0, neg: 1'b0, carry: 1'b0, ovf: 1'b0};

endpackage

// File: rtl/alu_addsub.sv
// rtl/alu_addsub.sv - combinational add/subtract with carry (not-borrow) and signed overflow
module alu_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             a_msb;
  logic             b_msb;
  logic             r_msb;

  // Subtract is A + ~B + 1, so the carry-out reads as NOT borrow.
  assign b_eff = (sub == OP_SUB) ? ~b : b;
  assign sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};

  assign result = sum[WIDTH-1:0];
  assign carry  = sum[WIDTH];

  assign a_msb = a[WIDTH-1];
  assign b_msb = b[WIDTH-1];
  assign r_msb = sum[WIDTH-1];

  always_comb begin
    ovf = 1'b0;
    if (sub == OP_SUB) begin
      ovf = (a_msb != b_msb) && (r_msb != a_msb);
    end else begin
      ovf = (a_msb == b_msb) && (r_msb != a_msb);
    end
  end

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - accumulator-style alu: operand register A, result register G and registered flags
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ain,
  input  logic             gin,
  input  logic             sub,
  input  logic [WIDTH-1:0] buswires,
  output logic [WIDTH-1:0] aluout,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf
);

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] g_reg;
  alu_flags_t       flags_reg;

  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_ovf;

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a      (a_reg),
    .b      (buswires),
    .sub    (sub),
    .result (r_result),
    .carry  (r_carry),
    .ovf    (r_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
    end else if (ain) begin
      a_reg <= buswires;
    end
  end

  // G samples the sum of the pre-edge A, so ain and gin together chain naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      g_reg     <= '0;
      flags_reg <= FLAGS_CLEAR;
    end else if (gin) begin
      g_reg           <= r_result;
      flags_reg.zero  <= (r_result == '0);
      flags_reg.neg   <= r_result[WIDTH-1];
      flags_reg.carry <= r_carry;
      flags_reg.ovf   <= r_ovf;
    end
  end

  assign aluout = g_reg;
  assign zero   = flags_reg.zero;
  assign neg    = flags_reg.neg;
  assign carry  = flags_reg.carry;
  assign ovf    = flags_reg.ovf;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - scoreboard bench for alu against an integer-arithmetic reference model
module tb_alu;

  localparam int W = 16;
  localparam longint MODV = longint'(1) << W;
  localparam longint SMAX = (longint'(1) << (W - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (W - 1));

  logic         clk = 1'b0;
  logic         rst;
  logic         ain;
  logic         gin;
  logic         sub;
  logic [W-1:0] buswires;
  logic [W-1:0] aluout;
  logic         zero;
  logic         neg;
  logic         carry;
  logic         ovf;

  always #5 clk = ~clk;

  alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .ain      (ain),
    .gin      (gin),
    .sub      (sub),
    .buswires (buswires),
    .aluout   (aluout),
    .zero     (zero),
    .neg      (neg),
    .carry    (carry),
    .ovf      (ovf)
  );

  typedef struct {
    string        tag;
    logic [W+3:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  bit   done  = 1'b0;

  longint a_m = 0;
  longint g_m = 0;
  bit     z_m = 1'b0;
  bit     n_m = 1'b0;
  bit     c_m = 1'b0;
  bit     v_m = 1'b0;

  function automatic longint to_signed(longint u);
    return (u > SMAX) ? u - MODV : u;
  endfunction

  // Applies one cycle of inputs, advances the model, and queues what G and flags must show after the edge.
  task automatic cycle(string tag, bit r, bit ai, bit gi, bit s, longint b);
    longint raw;
    longint sr;
    exp_t   e;
    rst      = r;
    ain      = ai;
    gin      = gi;
    sub      = s;
    buswires = W'(b);
    if (r) begin
      a_m = 0; g_m = 0; z_m = 0; n_m = 0; c_m = 0; v_m = 0;
    end else begin
      if (gi) begin
        raw = s ? a_m - b : a_m + b;
        sr  = s ? to_signed(a_m) - to_signed(b) : to_signed(a_m) + to_signed(b);
        g_m = ((raw % MODV) + MODV) % MODV;
        z_m = (g_m == 0);
        n_m = (g_m >= MODV / 2);
        c_m = s ? (a_m >= b) : (raw >= MODV);
        v_m = (sr > SMAX) || (sr < SMIN);
      end
      if (ai) a_m = b;
    end
    @(posedge clk);
    e.tag = tag;
    e.exp = {W'(g_m), z_m, n_m, c_m, v_m};
    sbq.push_back(e);
    #1;
  endtask

  exp_t cur;
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      cur = sbq.pop_front();
      tests++;
      if ({aluout, zero, neg, carry, ovf} !== cur.exp) begin
        fails++;
        $display("FAIL %s: got aluout=%h z=%b n=%b c=%b v=%b, expected aluout=%h z=%b n=%b c=%b v=%b",
                 cur.tag, aluout, zero, neg, carry, ovf,
                 cur.exp[W+3:4], cur.exp[3], cur.exp[2], cur.exp[1], cur.exp[0]);
      end
    end
  end

  initial begin
    #100000;
    if (!done) begin
      fails++;
      $display("FAIL timeout: stimulus did not complete within the wait limit");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  initial begin
    longint b;
    int     k;
    rst = 1'b1; ain = 1'b0; gin = 1'b0; sub = 1'b0; buswires = '0;
    #1;

    cycle("reset", 1, 0, 0, 0, 0);
    cycle("idle_after_reset", 0, 0, 0, 0, 16'h1234);
    cycle("idle_after_reset2", 0, 0, 0, 1, 16'hBEEF);

    tests++;
    if ({aluout, zero, neg, carry, ovf} !== '0) begin
      fails++;
      $display("FAIL reset_state: got aluout=%h z=%b n=%b c=%b v=%b, expected all zero",
               aluout, zero, neg, carry, ovf);
    end

    for (int i = 1; i <= 6; i++) cycle("chain_add", 0, 1, 1, 0, i);
    cycle("chain_add_repeat6", 0, 1, 1, 0, 6);

    cycle("load_a6", 0, 1, 0, 0, 6);
    cycle("sub_6_minus_7", 0, 0, 1, 1, 7);
    cycle("load_a7", 0, 1, 0, 0, 7);
    cycle("sub_7_minus_6", 0, 0, 1, 1, 6);

    cycle("load_a5", 0, 1, 0, 0, 5);
    cycle("sub_5_minus_5", 0, 0, 1, 1, 5);

    cycle("load_a7fff", 0, 1, 0, 0, 16'h7FFF);
    cycle("add_signed_ovf", 0, 0, 1, 0, 1);
    cycle("load_affff", 0, 1, 0, 0, 16'hFFFF);
    cycle("add_carry_wrap", 0, 0, 1, 0, 1);
    cycle("load_a8000", 0, 1, 0, 0, 16'h8000);
    cycle("sub_signed_ovf", 0, 0, 1, 1, 1);

    for (int i = 0; i < 4; i++) cycle("hold_gin0", 0, 1, 0, i[0], $urandom_range(0, 16'hFFFF));
    cycle("rst_over_gin", 1, 1, 1, 0, 16'h00F0);
    cycle("after_rst_add", 0, 0, 1, 0, 16'h0003);

    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 7);
      case (k)
        0: b = 0;
        1: b = 16'hFFFF;
        2: b = 16'h7FFF;
        3: b = 16'h8000;
        default: b = $urandom_range(0, 16'hFFFF);
      endcase
      cycle("random", ($urandom_range(0, 39) == 0), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
            $urandom_range(0, 1), b);
    end

    cycle("drain", 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected results never compared", sbq.size());
    end
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the data path width in bits; all data ports and registers are WIDTH bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port ain, input, 1 bit: load enable for operand register A.
REQ-005 SHALL have port gin, input, 1 bit: load enable for result register G.
REQ-006 SHALL have port sub, input, 1 bit: operation select; 0 = add, 1 = subtract.
REQ-007 SHALL have port buswires, input, WIDTH bits: shared data bus, the second operand and the source for A.
REQ-008 SHALL have port aluout, output, WIDTH bits: the contents of register G.
REQ-009 SHALL have port zero, output, 1 bit: registered flag, set when the value captured into G is 0.
REQ-010 SHALL have port neg, output, 1 bit: registered flag, equal to the MSB of the value captured into G.
REQ-011 SHALL have port carry, output, 1 bit: registered carry-out of the add, or NOT borrow for a subtract.
REQ-012 SHALL have port ovf, output, 1 bit: registered two's-complement signed overflow of the operation.

Function
REQ-013 SHALL hold internal register A (WIDTH bits); on a clock edge with ain=1, A <= buswires; otherwise A holds.
REQ-014 SHALL compute combinationally R = A + buswires when sub=0 and R = A - buswires (A + ~buswires + 1) when sub=1, using the current (pre-edge) value of A.
REQ-015 SHALL, on a clock edge with gin=1, load G <= R[WIDTH-1:0] and update zero, neg, carry and ovf from the same operation; with gin=0, G and all flags hold.
REQ-016 SHALL wrap results modulo 2^WIDTH with no saturation.
REQ-017 SHALL behave as follows when ain and gin are both 1 on the same edge: G uses the old A, and A takes the new buswires value at that edge.
REQ-018 SHALL drive aluout directly from G, so a G update is visible on aluout one cycle after the operands are presented, with no combinational path from inputs to aluout.
REQ-019 SHALL compute ovf for add as (A[msb]==B[msb]) && (R[msb]!=A[msb]), and for subtract as (A[msb]!=B[msb]) && (R[msb]!=A[msb]), where B is buswires.

Reset
REQ-020 SHALL clear A, G, zero, neg, carry and ovf to 0 on a clock edge with rst=1, so aluout = 0.
REQ-021 SHALL give rst priority over ain and gin; the flags SHALL read 0 after reset, not recomputed from G.
REQ-022 SHALL have no asynchronous reset path; a reset asserted mid-sequence takes effect only at the next edge.

Structure
REQ-023 SHALL place WIDTH's default value and the opcode constants (OP_ADD=0, OP_SUB=1) in a shared package, alu_pkg.
REQ-024 SHALL implement the adder/subtractor and flag generation as one combinational sub-module, alu_addsub, with inputs a, b and sub and outputs result, carry and ovf; the registers SHALL live in alu.

Verification
REQ-025 SHALL cover this case: with rst pulsed for 1 cycle, then all enables at 0 for 2 cycles, aluout=0 and all flags are 0.
REQ-026 SHALL cover this case: with ain=gin=1, sub=0 and buswires driven 1,2,3,4,5,6 on successive edges, after A=0 from reset, aluout is 1,3,5,7,9,11, and after a second edge at 6 it is 12.
REQ-027 SHALL cover this case: with A=6, sub=1 and buswires=7, the next aluout is 0xFFFF with neg=1, carry=0 and zero=0; then with buswires=6 and A=7, aluout=1 and carry=1.
REQ-028 SHALL cover this case: with A=5, sub=1 and buswires=5, aluout=0, zero=1 and carry=1.
REQ-029 SHALL cover this case: with A=0x7FFF, sub=0 and buswires=1, aluout=0x8000, ovf=1 and neg=1; with A=0xFFFF, sub=0 and buswires=1, aluout=0, carry=1 and ovf=0.
REQ-030 SHALL cover this case: with gin=0 and ain=1 while buswires changes, aluout and the flags hold; rst asserted while gin=1 gives aluout=0 at that edge.
